csr_unit: RTL and testbench

//  Machine-mode CSR file and trap sequencer. It is the responder to the CSR/MRET/interrupt controls produced by the decoder.
//  It executes CSRRW/CSRRS/CSRRC, keeps mstatus/mie/mip/mtvec/mepc/mcause/mcycle, takes external interrupts and executes MRET.
//  It also drives the PC redirect. It sits beside the register file; rdata feeds the writeback MUX.

---
 rtl/csr_pkg.sv | 33 +++
 rtl/csr_unit_irq_sync.sv | 22 ++
 rtl/csr_unit.sv | 171 +++++++++++++++++
 tb/tb_csr_unit.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode CSR unit: addresses, op/state encodings, field positions.
package csr_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MIE     = 12'h304;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MIP     = 12'h344;
  localparam logic [11:0] CSR_MCYCLE  = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH = 12'hB80;

  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;
  localparam int MIE_MEIE     = 11;
  localparam int MIP_MEIP     = 11;

  localparam logic [31:0] CAUSE_MEI = 32'h8000_000B;

  typedef enum logic [1:0] {
    CSR_OP_NONE = 2'b00,
    CSR_OP_RW   = 2'b01,
    CSR_OP_RS   = 2'b10,
    CSR_OP_RC   = 2'b11
  } csr_op_e;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_TRAP = 2'd1,
    ST_RET  = 2'd2
  } csr_state_e;

endpackage

// File: rtl/csr_unit_irq_sync.sv
// Multi-flop synchronizer bringing the asynchronous external interrupt level into the clk domain.
module csr_unit_irq_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;

  always_comb sync_d = {sync_q[SYNC_STAGES-2:0], d};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= sync_d;
  end

  assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/csr_unit.sv
// Machine-mode CSR file, external-interrupt trap entry and MRET sequencer with PC redirect.
// Optional CSR_VECTORED_EN: writable mtvec.MODE[0] and vectored interrupt entry.
module csr_unit
  import csr_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter int              SYNC_STAGES = 2,
  parameter logic [XLEN-1:0] MTVEC_RST   = XLEN'(32'h0000_0100)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            instr_valid,
  input  logic [XLEN-1:0] pc_in,
  input  logic            csr_rd_en,
  input  logic            csr_wr_en,
  input  logic [1:0]      csr_op,
  input  logic [11:0]     csr_addr,
  input  logic [XLEN-1:0] csr_wdata,
  input  logic            is_mret,
  input  logic            ext_irq,
  output logic [XLEN-1:0] csr_rdata,
  output logic            csr_illegal,
  output logic            redirect,
  output logic [XLEN-1:0] redirect_pc
);

`ifdef CSR_VECTORED_EN
  localparam logic [XLEN-1:0] MTVEC_MASK = ~XLEN'(2);
`else
  localparam logic [XLEN-1:0] MTVEC_MASK = ~XLEN'(3);
`endif
  localparam logic [XLEN-1:0] MEPC_MASK = ~XLEN'(3);

  csr_state_e        state_q, state_d;
  logic              mst_mie_q, mst_mie_d, mst_mpie_q, mst_mpie_d;
  logic              meie_q, meie_d;
  logic [XLEN-1:0]   mtvec_q, mtvec_d, mepc_q, mepc_d, mcause_q, mcause_d;
  logic [2*XLEN-1:0] mcycle_q, mcycle_d;

  logic            meip, legal, irq_take, mret_fire, wr_fire, wr_nonzero;
  logic [XLEN-1:0] csr_old, csr_new, mtvec_base, trap_vec;
  csr_op_e         op;

  csr_unit_irq_sync #(.SYNC_STAGES(SYNC_STAGES)) u_irq_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (ext_irq),
    .q     (meip)
  );

  // Pre-write view of the addressed CSR; unimplemented addresses read 0.
  always_comb begin
    csr_old = '0;
    legal   = 1'b1;
    case (csr_addr)
      CSR_MSTATUS: begin
        csr_old[MSTATUS_MIE]  = mst_mie_q;
        csr_old[MSTATUS_MPIE] = mst_mpie_q;
      end
      CSR_MIE:     csr_old[MIE_MEIE] = meie_q;
      CSR_MTVEC:   csr_old = mtvec_q;
      CSR_MEPC:    csr_old = mepc_q;
      CSR_MCAUSE:  csr_old = mcause_q;
      CSR_MIP:     csr_old[MIP_MEIP] = meip;
      CSR_MCYCLE:  csr_old = mcycle_q[XLEN-1:0];
      CSR_MCYCLEH: csr_old = mcycle_q[2*XLEN-1:XLEN];
      default:     legal = 1'b0;
    endcase
  end

  always_comb begin
    op         = csr_op_e'(csr_op);
    wr_nonzero = |csr_wdata;
    case (op)
      CSR_OP_RW: csr_new = csr_wdata;
      CSR_OP_RS: csr_new = csr_old | csr_wdata;
      CSR_OP_RC: csr_new = csr_old & ~csr_wdata;
      default:   csr_new = csr_old;
    endcase
  end

  // The interrupt wins over MRET and over any CSR write in the same cycle.
  assign irq_take  = instr_valid & (state_q == ST_RUN) & mst_mie_q & meie_q & meip;
  assign mret_fire = instr_valid & (state_q == ST_RUN) & is_mret & ~irq_take;
  assign wr_fire   = instr_valid & (state_q == ST_RUN) & csr_wr_en & legal & ~irq_take &
                     ((op == CSR_OP_RW) | (((op == CSR_OP_RS) | (op == CSR_OP_RC)) & wr_nonzero));

  assign mtvec_base = mtvec_q & ~XLEN'(3);
`ifdef CSR_VECTORED_EN
  assign trap_vec = mtvec_q[0] ? mtvec_base + XLEN'({mcause_q[4:0], 2'b00}) : mtvec_base;
`else
  assign trap_vec = mtvec_base;
`endif

  assign csr_rdata   = (rst_n & csr_rd_en) ? csr_old : '0;
  assign csr_illegal = rst_n & (csr_rd_en | csr_wr_en) & ~legal;
  assign redirect    = (state_q != ST_RUN);
  assign redirect_pc = (state_q == ST_TRAP) ? trap_vec :
                       (state_q == ST_RET)  ? mepc_q   : '0;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (irq_take)       state_d = ST_TRAP;
        else if (mret_fire) state_d = ST_RET;
      end
      ST_TRAP: state_d = ST_RUN;
      ST_RET:  state_d = ST_RUN;
      default: state_d = ST_RUN;
    endcase
  end

  always_comb begin
    mst_mie_d  = mst_mie_q;
    mst_mpie_d = mst_mpie_q;
    meie_d     = meie_q;
    mtvec_d    = mtvec_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    mcycle_d   = mcycle_q + (2*XLEN)'(1);
    if (wr_fire) begin
      case (csr_addr)
        CSR_MSTATUS: begin
          mst_mie_d  = csr_new[MSTATUS_MIE];
          mst_mpie_d = csr_new[MSTATUS_MPIE];
        end
        CSR_MIE:     meie_d   = csr_new[MIE_MEIE];
        CSR_MTVEC:   mtvec_d  = csr_new & MTVEC_MASK;
        CSR_MEPC:    mepc_d   = csr_new & MEPC_MASK;
        CSR_MCAUSE:  mcause_d = csr_new;
        // A half-write freezes the whole counter for that cycle.
        CSR_MCYCLE:  mcycle_d = {mcycle_q[2*XLEN-1:XLEN], csr_new};
        CSR_MCYCLEH: mcycle_d = {csr_new, mcycle_q[XLEN-1:0]};
        default: ;
      endcase
    end
    if (irq_take) begin
      mepc_d     = pc_in & MEPC_MASK;
      mcause_d   = XLEN'(CAUSE_MEI);
      mst_mpie_d = mst_mie_q;
      mst_mie_d  = 1'b0;
    end else if (mret_fire) begin
      mst_mie_d  = mst_mpie_q;
      mst_mpie_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_RUN;
      mst_mie_q  <= 1'b0;
      mst_mpie_q <= 1'b0;
      meie_q     <= 1'b0;
      mtvec_q    <= MTVEC_RST & MTVEC_MASK;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mcycle_q   <= '0;
    end else begin
      state_q    <= state_d;
      mst_mie_q  <= mst_mie_d;
      mst_mpie_q <= mst_mpie_d;
      meie_q     <= meie_d;
      mtvec_q    <= mtvec_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      mcycle_q   <= mcycle_d;
    end
  end

endmodule

// File: tb/tb_csr_unit.sv
// Scoreboard bench for csr_unit: read results and redirect targets are queued at drive time and popped by a monitor.
module tb_csr_unit;
  import csr_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid, csr_rd_en, csr_wr_en, is_mret, ext_irq;
  logic [31:0] pc_in, csr_wdata, csr_rdata, redirect_pc;
  logic [1:0]  csr_op;
  logic [11:0] csr_addr;
  logic        csr_illegal, redirect;

  typedef struct {
    string       tag;
    logic [31:0] rdata;
    logic        ill;
  } rd_exp_t;

  rd_exp_t     rd_q[$];
  logic [31:0] redir_q[$];
  int          n_chk = 0;
  int          n_bad = 0;

  csr_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .pc_in       (pc_in),
    .csr_rd_en   (csr_rd_en),
    .csr_wr_en   (csr_wr_en),
    .csr_op      (csr_op),
    .csr_addr    (csr_addr),
    .csr_wdata   (csr_wdata),
    .is_mret     (is_mret),
    .ext_irq     (ext_irq),
    .csr_rdata   (csr_rdata),
    .csr_illegal (csr_illegal),
    .redirect    (redirect),
    .redirect_pc (redirect_pc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // One instruction slot: drive just after posedge, consumed by the next posedge.
  task automatic op(input logic v, input logic rd, input logic wr, input logic [1:0] opc,
                    input logic [11:0] a, input logic [31:0] wd, input logic mret,
                    input logic [31:0] pc, input string tag, input logic [31:0] exp_rd,
                    input logic exp_ill);
    rd_exp_t e;
    @(posedge clk);
    #1;
    instr_valid = v;  csr_rd_en = rd;  csr_wr_en = wr;  csr_op = opc;
    csr_addr = a;     csr_wdata = wd;  is_mret = mret;  pc_in = pc;
    if (rd) begin
      e.tag = tag;  e.rdata = exp_rd;  e.ill = exp_ill;
      rd_q.push_back(e);
    end
  endtask

  task automatic idle();
    op(1'b0, 1'b0, 1'b0, 2'b00, 12'h000, 32'h0, 1'b0, 32'h0, "", 32'h0, 1'b0);
  endtask

  task automatic rd(input string tag, input logic [11:0] a, input logic [31:0] exp);
    op(1'b0, 1'b1, 1'b0, 2'b00, a, 32'h0, 1'b0, 32'h0, tag, exp, 1'b0);
  endtask

  task automatic csrw(input string tag, input logic [1:0] opc, input logic [11:0] a,
                      input logic [31:0] wd, input logic [31:0] pc, input logic [31:0] exp_old);
    op(1'b1, 1'b1, 1'b1, opc, a, wd, 1'b0, pc, tag, exp_old, 1'b0);
  endtask

  task automatic nop(input logic [31:0] pc, input logic mret);
    op(1'b1, 1'b0, 1'b0, 2'b00, 12'h000, 32'h0, mret, pc, "", 32'h0, 1'b0);
  endtask

  always @(negedge clk) begin
    rd_exp_t     e;
    logic [31:0] p;
    if (rst_n) begin
      if (csr_rd_en) begin
        if (rd_q.size() == 0) begin
          n_chk++; n_bad++;
          $display("FAIL rd_unexpected: got read %h want no read", csr_rdata);
        end else begin
          e = rd_q.pop_front();
          chk(e.tag, csr_rdata, e.rdata);
          chk({e.tag, "_ill"}, {31'h0, csr_illegal}, {31'h0, e.ill});
        end
      end
      if (redirect) begin
        if (redir_q.size() == 0) begin
          n_chk++; n_bad++;
          $display("FAIL redir_unexpected: got redirect to %h want none", redirect_pc);
        end else begin
          p = redir_q.pop_front();
          chk("redirect_pc", redirect_pc, p);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;  instr_valid = 1'b0;  csr_wr_en = 1'b0;  csr_op = 2'b00;
    csr_wdata = '0;  is_mret = 1'b0;  ext_irq = 1'b0;  pc_in = '0;
    csr_rd_en = 1'b1;  csr_addr = CSR_MTVEC;
    #3;
    chk("rst_redirect", {31'h0, redirect}, 32'h0);
    chk("rst_illegal", {31'h0, csr_illegal}, 32'h0);
    chk("rst_rdata", csr_rdata, 32'h0);
    chk("rst_redirect_pc", redirect_pc, 32'h0);
    #4;
    csr_rd_en = 1'b0;
    rst_n = 1'b1;

    rd("rst_mtvec", CSR_MTVEC, 32'h100);
    rd("rst_mstatus", CSR_MSTATUS, 32'h0);
    rd("rst_mcause", CSR_MCAUSE, 32'h0);

    csrw("rw_mtvec_old", CSR_OP_RW, CSR_MTVEC, 32'h200, 32'h0, 32'h100);
    csrw("rs_mstatus_old", CSR_OP_RS, CSR_MSTATUS, 32'h8, 32'h4, 32'h0);
    rd("mtvec_new", CSR_MTVEC, 32'h200);
    rd("mstatus_mie", CSR_MSTATUS, 32'h8);
    csrw("rs_mie_old", CSR_OP_RS, CSR_MIE, 32'h800, 32'h8, 32'h0);
    csrw("rs_zero_mie", CSR_OP_RC, CSR_MIE, 32'h0, 32'hC, 32'h800);
    rd("mie_meie", CSR_MIE, 32'h800);
    op(1'b0, 1'b1, 1'b0, 2'b00, 12'h7FF, 32'h0, 1'b0, 32'h0, "illegal_rd", 32'h0, 1'b1);

    // Interrupt latency and trap entry.
    ext_irq = 1'b1;
    rd("mip_sync1", CSR_MIP, 32'h0);
    rd("mip_sync2", CSR_MIP, 32'h800);
    redir_q.push_back(32'h200);
    nop(32'h40, 1'b0);
    idle();
    ext_irq = 1'b0;
    rd("trap_mepc", CSR_MEPC, 32'h40);
    rd("trap_mcause", CSR_MCAUSE, 32'h8000_000B);
    rd("trap_mstatus", CSR_MSTATUS, 32'h80);

    redir_q.push_back(32'h40);
    nop(32'h80, 1'b1);
    idle();
    rd("mret_mstatus", CSR_MSTATUS, 32'h88);

    // MRET racing an interrupt.
    ext_irq = 1'b1;
    rd("mip_a1", CSR_MIP, 32'h0);
    rd("mip_a2", CSR_MIP, 32'h800);
    redir_q.push_back(32'h200);
    nop(32'h60, 1'b1);
    idle();
    ext_irq = 1'b0;
    rd("race_mret_mepc", CSR_MEPC, 32'h60);
    rd("race_mret_mstatus", CSR_MSTATUS, 32'h80);
    rd("mip_clear", CSR_MIP, 32'h0);

    // CSRRC clearing MIE racing an interrupt.
    csrw("rs_mstatus2", CSR_OP_RS, CSR_MSTATUS, 32'h8, 32'h70, 32'h80);
    ext_irq = 1'b1;
    rd("mip_b1", CSR_MIP, 32'h0);
    rd("mip_b2", CSR_MIP, 32'h800);
    redir_q.push_back(32'h200);
    csrw("race_rc_old", CSR_OP_RC, CSR_MSTATUS, 32'h8, 32'h90, 32'h88);
    idle();
    ext_irq = 1'b0;
    rd("race_rc_mstatus", CSR_MSTATUS, 32'h80);
    rd("race_rc_mepc", CSR_MEPC, 32'h90);
    rd("race_rc_mie", CSR_MIE, 32'h800);

    // mcycle carry across the halves.
    op(1'b1, 1'b0, 1'b1, CSR_OP_RW, CSR_MCYCLE, 32'hFFFF_FFFF, 1'b0, 32'h0, "", 32'h0, 1'b0);
    op(1'b1, 1'b0, 1'b1, CSR_OP_RW, CSR_MCYCLEH, 32'h0, 1'b0, 32'h0, "", 32'h0, 1'b0);
    rd("mcycle_held", CSR_MCYCLE, 32'hFFFF_FFFF);
    rd("mcycle_wrap_lo", CSR_MCYCLE, 32'h0);
    rd("mcycle_wrap_hi", CSR_MCYCLEH, 32'h1);

    // mtvec MODE handling and trap vector.
    csrw("rw_mtvec_mode", CSR_OP_RW, CSR_MTVEC, 32'h201, 32'hA0, 32'h200);
`ifdef CSR_VECTORED_EN
    rd("mtvec_mode", CSR_MTVEC, 32'h201);
`else
    rd("mtvec_mode", CSR_MTVEC, 32'h200);
`endif
    csrw("rs_mstatus3", CSR_OP_RS, CSR_MSTATUS, 32'h8, 32'hA4, 32'h80);
    ext_irq = 1'b1;
    rd("mip_c1", CSR_MIP, 32'h0);
    rd("mip_c2", CSR_MIP, 32'h800);
`ifdef CSR_VECTORED_EN
    redir_q.push_back(32'h22C);
`else
    redir_q.push_back(32'h200);
`endif
    nop(32'hA0, 1'b0);
    idle();
    rd("vec_mstatus", CSR_MSTATUS, 32'h80);

    // Reset while the trap redirect is being issued.
    csrw("rs_mstatus4", CSR_OP_RS, CSR_MSTATUS, 32'h8, 32'hA8, 32'h80);
    nop(32'hB0, 1'b0);
    @(posedge clk);
    #1;
    chk("midtrap_redirect", {31'h0, redirect}, 32'h1);
    rst_n = 1'b0;  ext_irq = 1'b0;  instr_valid = 1'b0;
    #1;
    chk("rst_midtrap_redirect", {31'h0, redirect}, 32'h0);
    chk("rst_midtrap_pc", redirect_pc, 32'h0);
    #1;
    rst_n = 1'b1;
    rd("post_rst_mtvec", CSR_MTVEC, 32'h100);
    rd("post_rst_mstatus", CSR_MSTATUS, 32'h0);
    idle();
    idle();
    chk("rd_q_left", rd_q.size(), 32'h0);
    chk("redir_q_left", redir_q.size(), 32'h0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
